pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
//
// PURPOSE
// Parametrised, pipelined barrel shifter: the multi-mode successor of our fixed
// 8-bit rotator. Performs rotate-left/right, logical left/right and arithmetic
// right shift on a WIDTH-bit word by a runtime amount, one pipeline stage per
// shift-amount bit. Sits in datapaths that need a streaming shifter with
// valid/ready flow control and full-throughput back-to-back operation.
//
// PARAMETERS
// WIDTH  8                data width; power of two, >= 2
// SHW    $clog2(WIDTH)    shift-amount width = pipeline depth (derived, do not override)
//
// PORTS
// clk        in   1      clock, all logic on rising edge
// rst        in   1      synchronous reset, active-high
// in_valid   in   1      input beat valid
// in_ready   out  1      shifter can accept a beat this cycle
// in_data    in   WIDTH  operand a
// in_amt     in   SHW    shift amount s (0..WIDTH-1)
// in_mode    in   3      000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 pass-through
// out_valid  out  1      result beat valid
// out_ready  in   1      downstream accepts result
// out_data   out  WIDTH  shifted result y
// out_zero   out  1      out_data == 0 (qualified by out_valid)
//
// BEHAVIOUR
// - Reset: all stage valids 0, out_valid 0, out_data 0, out_zero 1; in_ready 1 the cycle after rst drops.
// - Reset mid-operation: every in-flight beat is discarded; no stale result appears after reset.
// - Stage k (k = 0..SHW-1) applies a shift of 2^k iff amount bit k is set; stages
//   ordered LSB first. Each stage registers data, mode, amount, valid.
// - Latency: exactly SHW cycles from accepted beat (in_valid & in_ready) to out_valid, absent stalls.
// - Throughput: one beat per cycle when out_ready held high.
// - Flow control: global stall. advance = !out_valid | out_ready; in_ready = advance.
//   When advance = 0, all stage registers (including bubbles) hold; out_data stable.
// - Beat order preserved; no beat dropped or duplicated under any out_ready pattern.
// - in_data/in_amt/in_mode ignored when in_valid = 0 or in_ready = 0.
// - Mode rules: ROL/ROR wrap bits around; SLL/SRL fill with 0; SRA fills with in_data[WIDTH-1];
//   pass-through modes output in_data unchanged regardless of in_amt.
// - Amount 0: out_data = in_data for every mode; latency unchanged.
// - out_zero computed from out_data combinationally (or registered with it); never stale.
//
// TESTING (WIDTH = 8, SHW = 3)
// 1. ROL a=8'b10101010 s=1 -> out_valid 3 cycles later, y=8'b01010101, out_zero=0.
// 2. ROR a=8'b11101011 s=3 -> y=8'b01111101; SRA a=8'b10100010 s=4 -> y=8'b11111010;
//    SRL same a s=4 -> y=8'b00001010.
// 3. SLL a=8'b00010100 s=7 -> y=8'b00000000, out_zero=1; mode 101 a=8'hA5 s=5 -> y=8'hA5.
// 4. Streaming: 8 back-to-back beats, out_ready=1 -> 8 results on 8 consecutive cycles, in order,
//    each matching a reference model over all modes and s=0..7.
// 5. Backpressure: out_ready=0, in_valid=1 continuously -> exactly 3 beats accepted, in_ready=0
//    from cycle 3; release out_ready -> 3 results in order, out_data held stable while stalled.
// 6. Reset mid-stream: 2 beats in flight, assert rst 1 cycle -> out_valid=0, no result from those
//    beats ever emerges; new beat after reset returns correct result after 3 cycles.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
//============================================================================
// Module   : pipelined_barrel_shifter
// Purpose  : Streaming multi-mode barrel shifter. Each pipeline stage applies
//            a shift of 2^k when bit k of the beat's amount is set, so the
//            depth equals the shift-amount width.
//            Modes: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 pass.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready/in_data/in_amt/in_mode   - operand beat
//            out_valid/out_ready/out_data/out_zero      - result beat
// Revision : 1.0  initial release
//============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [2:0] MODE_ROL = 3'b000;
    localparam logic [2:0] MODE_ROR = 3'b001;
    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_SRA = 3'b100;

    // Per-stage registers; index k holds the beat after stages 0..k applied.
    logic [SHW-1:0][WIDTH-1:0] data_q,  data_d;
    logic [SHW-1:0][SHW-1:0]   amt_q,   amt_d;
    logic [SHW-1:0][2:0]       mode_q,  mode_d;
    logic [SHW-1:0]            valid_q, valid_d;

    // Source of each stage: entry 0 is the input port, entry k is stage k-1.
    logic [SHW:0][WIDTH-1:0]   src_data;
    logic [SHW:0][SHW-1:0]     src_amt;
    logic [SHW:0][2:0]         src_mode;
    logic [SHW:0]              src_valid;

    logic                      advance;

    assign src_data  = {data_q,  in_data};
    assign src_amt   = {amt_q,   in_amt};
    assign src_mode  = {mode_q,  in_mode};
    assign src_valid = {valid_q, in_valid};

    // Global stall: the whole pipe moves only when the output slot frees up.
    assign advance   = !valid_q[SHW-1] || out_ready;
    assign in_ready  = advance;

    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_zero  = (data_q[SHW-1] == '0);

    // The last stage's sideband and the already-consumed amount bits have
    // no reader; fold them into a sink so they are visibly intentional.
    logic unused_sideband;
    assign unused_sideband = ^{amt_q, mode_q[SHW-1]};

    // Shift d by n (n < WIDTH) according to mode.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input int unsigned      n
    );
        case (mode)
            MODE_ROL: shift_by = (d << n) | (d >> (WIDTH - n));
            MODE_ROR: shift_by = (d >> n) | (d << (WIDTH - n));
            MODE_SLL: shift_by = d << n;
            MODE_SRL: shift_by = d >> n;
            MODE_SRA: shift_by = $unsigned($signed(d) >>> n);
            default:  shift_by = d;
        endcase
    endfunction

    always_comb begin
        data_d  = data_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        if (advance) begin
            for (int k = 0; k < SHW; k++) begin
                valid_d[k] = src_valid[k];
                amt_d[k]   = src_amt[k];
                mode_d[k]  = src_mode[k];
                data_d[k]  = src_amt[k][k]
                           ? shift_by(src_data[k], src_mode[k], 32'd1 << k)
                           : src_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
//============================================================================
// Module   : tb_pipelined_barrel_shifter
// Purpose  : Self-checking bench for pipelined_barrel_shifter (WIDTH = 8).
//            Directed vectors, random streaming, backpressure and reset
//            mid-stream, checked against a whole-word reference model.
// Revision : 1.0  initial release
//============================================================================
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [7:0] y;
        int         t;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    bit   lat_chk = 1'b1;
    logic [7:0] held;

    // Whole-word reference: rotates via a doubled word, SRA via a
    // sign-extended double word.
    function automatic logic [7:0] ref_shift(input logic [7:0] a, input int s,
                                             input logic [2:0] m);
        logic [15:0] w;
        case (m)
            3'd0: begin w = {a, a} << s;           return w[15:8]; end
            3'd1: begin w = {a, a} >> s;           return w[7:0];  end
            3'd2: begin w = {8'h00, a} << s;       return w[7:0];  end
            3'd3: begin w = {8'h00, a} >> s;       return w[7:0];  end
            3'd4: begin w = {{8{a[7]}}, a} >> s;   return w[7:0];  end
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1ns later, and
    // account for both handshakes that the next rising edge will complete.
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] a,
                        input logic [2:0] m, input logic ordy, input int expv);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        in_mode   = m;
        out_ready = ordy;
        #1;
        cyc++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e.y});
                chk("out_zero", {31'd0, out_zero}, {31'd0, (e.y == 8'd0)});
                if (lat_chk) chk("latency", cyc - e.t, 32'd3);
            end
        end
        if (in_valid && in_ready) begin
            e.y = (expv < 0) ? ref_shift(d, int'(a), m) : expv[7:0];
            e.t = cyc;
            sb.push_back(e);
            n_acc++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, -1);
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_out_zero",  {31'd0, out_zero},  32'd1);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Directed vectors with hand-derived results
        step(1'b1, 8'b10101010, 3'd1, 3'b000, 1'b1, 8'b01010101);
        drain();
        step(1'b1, 8'b11101011, 3'd3, 3'b001, 1'b1, 8'b01111101);
        step(1'b1, 8'b10100010, 3'd4, 3'b100, 1'b1, 8'b11111010);
        step(1'b1, 8'b10100010, 3'd4, 3'b011, 1'b1, 8'b00001010);
        step(1'b1, 8'b00010100, 3'd7, 3'b010, 1'b1, 8'b00000000);
        step(1'b1, 8'hA5,       3'd5, 3'b101, 1'b1, 8'hA5);
        step(1'b1, 8'h3C,       3'd0, 3'b100, 1'b1, 8'h3C);
        drain();

        // Back-to-back stream over every amount; latency check proves
        // results land on consecutive cycles.
        for (int i = 0; i < 8; i++)
            step(1'b1, 8'($urandom), 3'(i), 3'($urandom_range(0, 7)), 1'b1, -1);
        drain();

        // Backpressure with output held off
        lat_chk = 1'b0;
        n_acc   = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, -1);
            if (i >= 3) begin
                chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            end
            if (i == 3) held = out_data;
            if (i > 3) chk("bp_hold_data", {24'd0, out_data}, {24'd0, held});
        end
        chk("bp_accepts", n_acc, 32'd3);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), -1);
        drain();

        // Reset with two beats in flight
        lat_chk = 1'b1;
        step(1'b1, 8'h81, 3'd1, 3'b000, 1'b1, -1);
        step(1'b1, 8'h7E, 3'd2, 3'b011, 1'b1, -1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_out_zero",  {31'd0, out_zero},  32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, -1);
            chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        step(1'b1, 8'b10100010, 3'd4, 3'b100, 1'b1, 8'b11111010);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
